ppu_trace_buffer: RTL and testbench

- Synthesizable pipeline trace capture unit for the PA-RISC PPU; replaces simulation-only $display monitoring of fetch/control signals.
- Each enabled cycle it samples the IF-stage instruction, PC and a control bundle into a circular buffer, fires a masked opcode/instruction trigger, and keeps a programmable number of post-trigger entries.
- The frozen window is then drained oldest-first over a valid/ready port.
- Sits beside the pipeline top, fed by the IF instruction register, front PC and the concatenated CU control bundle.

---
 rtl/ppu_trace_buffer_pkg.sv | 17 +
 rtl/ppu_trace_buffer_mem.sv | 25 ++
 rtl/ppu_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_ppu_trace_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_trace_buffer_pkg.sv
// Shared definitions for the PPU pipeline trace buffer: FSM state encodings
// and a small helper for the trigger post-count clamp.
package ppu_trace_buffer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_READ = 2'd3;

  // Post-trigger entries can never exceed DEPTH-1, otherwise the trigger
  // entry itself would be overwritten before the window freezes.
  function automatic int unsigned clamp_post(input int unsigned req,
                                             input int unsigned depth);
    return (req > depth - 1) ? depth - 1 : req;
  endfunction

endpackage

// File: rtl/ppu_trace_buffer_mem.sv
// Trace storage: DEPTH x W flop array, one synchronous write port and one
// combinational read port.
module ppu_trace_buffer_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 104,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; readout is gated by level so stale words are never observed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppu_trace_buffer.sv
// Pipeline trace capture: circular pre-trigger history, masked instruction
// trigger, programmable post-trigger tail, then oldest-first valid/ready drain.
module ppu_trace_buffer
  import ppu_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 24,
  parameter int CYC_W  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       inst_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              arm,
  input  logic [31:0]       trig_val,
  input  logic [31:0]       trig_mask,
  input  logic [LW-1:0]     post_cnt,
  output logic              triggered,
  output logic              done,
  output logic [LW-1:0]     level,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_inst,
  output logic [PC_W-1:0]   rd_pc,
  output logic [CTRL_W-1:0] rd_ctrl,
  output logic [CYC_W-1:0]  rd_cyc
);

  localparam int EW = CYC_W + PC_W + 32 + CTRL_W;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    post_q, post_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             triggered_q, triggered_d;
  logic             done_q, done_d;

  logic             we;
  logic             freeze;
  logic             hit;
  logic [AW-1:0]    post_clamped;
  logic [EW-1:0]    wdata, rdata;

  assign hit          = ((inst_in ^ trig_val) & trig_mask) == 32'd0;
  assign post_clamped = AW'(clamp_post(int'(post_cnt), DEPTH));
  assign wdata        = {cyc_q, pc_in, inst_in, ctrl_in};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    post_d      = post_q;
    cyc_d       = cyc_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    we          = 1'b0;
    freeze      = 1'b0;

    if (arm) begin
      state_d     = ST_PRE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      post_d      = '0;
      cyc_d       = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_PRE, ST_POST: begin
          // Stamp counts clocks, not captures, so stalls show up as gaps.
          cyc_d = cyc_q + CYC_W'(1);
          if (en) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (level_q != LW'(DEPTH)) level_d = level_q + LW'(1);
            if (state_q == ST_PRE) begin
              if (hit) begin
                triggered_d = 1'b1;
                post_d      = post_clamped;
                if (post_clamped == '0) freeze = 1'b1;
                else                    state_d = ST_POST;
              end
            end else begin
              post_d = post_q - AW'(1);
              if (post_q == AW'(1)) freeze = 1'b1;
            end
          end
          if (freeze) begin
            state_d  = ST_READ;
            done_d   = 1'b1;
            // Oldest entry; a full window (level=DEPTH) wraps to wr_ptr itself.
            rd_ptr_d = wr_ptr_d - level_d[AW-1:0];
          end
        end
        ST_READ: begin
          if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - LW'(1);
            if (level_q == LW'(1)) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      post_q      <= '0;
      cyc_q       <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      post_q      <= post_d;
      cyc_q       <= cyc_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  ppu_trace_buffer_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign triggered = triggered_q;
  assign done      = done_q;
  assign level     = level_q;
  assign rd_valid  = (state_q == ST_READ);
  assign {rd_cyc, rd_pc, rd_inst, rd_ctrl} = rdata;

endmodule

// File: tb/tb_ppu_trace_buffer.sv
// Self-checking bench for ppu_trace_buffer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_ppu_trace_buffer;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 32;
  localparam int CTRL_W = 24;
  localparam int CYC_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [PC_W-1:0]   pc;
    logic [31:0]       inst;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic              clk;
  logic              reset;
  logic              en;
  logic [31:0]       inst_in;
  logic [PC_W-1:0]   pc_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              arm;
  logic [31:0]       trig_val;
  logic [31:0]       trig_mask;
  logic [LW-1:0]     post_cnt;
  logic              triggered;
  logic              done;
  logic [LW-1:0]     level;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_inst;
  logic [PC_W-1:0]   rd_pc;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [CYC_W-1:0]  rd_cyc;

  ppu_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .CTRL_W(CTRL_W), .CYC_W(CYC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .inst_in   (inst_in),
    .pc_in     (pc_in),
    .ctrl_in   (ctrl_in),
    .arm       (arm),
    .trig_val  (trig_val),
    .trig_mask (trig_mask),
    .post_cnt  (post_cnt),
    .triggered (triggered),
    .done      (done),
    .level     (level),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_inst   (rd_inst),
    .rd_pc     (rd_pc),
    .rd_ctrl   (rd_ctrl),
    .rd_cyc    (rd_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 post-trigger, 3 draining.
  int               m_mode;
  ent_t             m_q[$];
  logic [CYC_W-1:0] m_cyc;
  int               m_post;
  bit               m_trig;
  bit               m_done;

  function automatic void model_reset();
    m_mode = 0;
    m_q.delete();
    m_cyc  = '0;
    m_post = 0;
    m_trig = 0;
    m_done = 0;
  endfunction

  task automatic compare_outputs();
    check("triggered", {63'd0, triggered}, {63'd0, m_trig});
    check("done", {63'd0, done}, {63'd0, m_done});
    check("level", 64'(level), 64'(m_q.size()));
    check("rd_valid", {63'd0, rd_valid}, {63'd0, (m_mode == 3)});
    if (m_mode == 3 && m_q.size() > 0) begin
      check("rd_inst", 64'(rd_inst), 64'(m_q[0].inst));
      check("rd_pc", 64'(rd_pc), 64'(m_q[0].pc));
      check("rd_ctrl", 64'(rd_ctrl), 64'(m_q[0].ctrl));
      check("rd_cyc", 64'(rd_cyc), 64'(m_q[0].cyc));
    end
  endtask

  task automatic do_cycle(input bit a, input bit e, input logic [31:0] ins, input bit rr);
    ent_t s;
    arm      = a;
    en       = e;
    inst_in  = ins;
    rd_ready = rr;
    pc_in    = $urandom;
    ctrl_in  = CTRL_W'($urandom);
    if (a) begin
      m_mode = 1;
      m_q.delete();
      m_cyc  = '0;
      m_trig = 0;
      m_done = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (e) begin
        s.cyc  = m_cyc;
        s.pc   = pc_in;
        s.inst = ins;
        s.ctrl = ctrl_in;
        m_q.push_back(s);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        if (m_mode == 1) begin
          if (((ins ^ trig_val) & trig_mask) == 32'd0) begin
            m_trig = 1;
            m_post = (int'(post_cnt) > DEPTH - 1) ? DEPTH - 1 : int'(post_cnt);
            m_mode = (m_post == 0) ? 3 : 2;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_mode = 3;
        end
        if (m_mode == 3) m_done = 1;
      end
      m_cyc++;
    end else if (m_mode == 3 && rr) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_mode = 0;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  logic [CYC_W-1:0] stamps [DEPTH];
  int               n_st;

  initial begin
    model_reset();
    reset = 1'b0; arm = 1'b0; en = 1'b0; inst_in = '0; pc_in = '0; ctrl_in = '0;
    trig_val = '0; trig_mask = '0; post_cnt = '0; rd_ready = 1'b0;
    #12;
    compare_outputs();
    reset = 1'b1;

    // Long pre-history: trigger on 12 with 3 post entries, window is 8..15.
    trig_val = 32'd12; trig_mask = 32'hFFFF_FFFF; post_cnt = LW'(3);
    do_cycle(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 1, i, 1);
      if (i == 15) begin
        check("s1_level", 64'(level), 64'd8);
        check("s1_oldest", 64'(rd_inst), 64'd8);
        check("s1_cyc", 64'(rd_cyc), 64'd8);
      end
    end
    for (int i = 0; i < 6; i++) do_cycle(0, 1, 0, 1);
    check("s1_idle_done", {63'd0, done}, 64'd1);
    check("s1_idle_level", 64'(level), 64'd0);

    // Early trigger, post 0: only three real entries, trigger last.
    trig_val = 32'd3; post_cnt = LW'(0);
    do_cycle(1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) do_cycle(0, 1, i, 0);
    check("s2_level", 64'(level), 64'd3);
    check("s2_oldest", 64'(rd_inst), 64'd1);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 1);

    // Oversized post count clamps to DEPTH-1; ready pattern 1,0,0,1,1.
    trig_val = 32'd2; post_cnt = LW'(15);
    do_cycle(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      do_cycle(0, 1, i, 0);
      if (i == 9) begin
        check("s3_level", 64'(level), 64'd8);
        check("s3_oldest_trig", 64'(rd_inst), 64'd2);
      end
    end
    for (int k = 0; k < 20; k++) do_cycle(0, 0, 0, (k % 5 == 0) || (k % 5 >= 3));

    // Stalls during POST leave a gap in the cycle stamps.
    trig_val = 32'd5; post_cnt = LW'(2);
    do_cycle(1, 0, 0, 0);
    for (int i = 0; i <= 5; i++) do_cycle(0, 1, i, 0);
    do_cycle(0, 1, 6, 0);
    do_cycle(0, 0, 0, 0);
    do_cycle(0, 0, 0, 0);
    do_cycle(0, 1, 7, 0);
    check("s4_level", 64'(level), 64'd8);
    n_st = 0;
    for (int k = 0; k < 12; k++) begin
      if (rd_valid && n_st < DEPTH) begin
        stamps[n_st] = rd_cyc;
        n_st++;
      end
      do_cycle(0, 0, 0, 1);
    end
    check("s4_count", 64'(n_st), 64'd8);
    check("s4_gap", 64'(stamps[7] - stamps[6]), 64'd3);
    check("s4_step", 64'(stamps[1] - stamps[0]), 64'd1);

    // Asynchronous reset mid-POST, then arm while draining.
    trig_val = 32'd1; post_cnt = LW'(7);
    do_cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, i, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(posedge clk);
    #3;
    compare_outputs();
    reset = 1'b1;
    trig_val = 32'd2; post_cnt = LW'(0);
    do_cycle(1, 0, 0, 0);
    for (int i = 0; i <= 2; i++) do_cycle(0, 1, i, 0);
    check("s6_read_level", 64'(level), 64'd3);
    do_cycle(1, 1, 32'd77, 1);
    check("s6_rearm_level", 64'(level), 64'd0);
    check("s6_rearm_done", {63'd0, done}, 64'd0);
    check("s6_rearm_trig", {63'd0, triggered}, 64'd0);
    check("s6_rearm_valid", {63'd0, rd_valid}, 64'd0);

    // Random traffic with sparse trigger masks and occasional re-arms.
    for (int r = 0; r < 12; r++) begin
      trig_val  = $urandom;
      trig_mask = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
      post_cnt  = LW'($urandom_range(0, 15));
      do_cycle(1, $urandom_range(0, 1) == 1, $urandom, 1);
      for (int k = 0; k < 60; k++)
        do_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
